// File: rtl/ds_mux_pkg.sv
// Shared types and helpers for the delta-sigma bitstream mux scheduler.
// Holds the FSM state encoding, mux select constants and the channel id type.
package ds_mux_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_A  = 2'd1,
        GNT_B  = 2'd2,
        SWITCH = 2'd3
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_e;

    function automatic logic chan_sel(input chan_e ch);
        return (ch == CH_B) ? SEL_B : SEL_A;
    endfunction

    function automatic chan_e other_chan(input chan_e ch);
        return (ch == CH_A) ? CH_B : CH_A;
    endfunction

    // Round-robin pick: on contention the channel that did not hold last wins.
    function automatic chan_e arb_target(input logic req_a, input logic req_b, input chan_e last);
        if (req_a && req_b) begin
            return other_chan(last);
        end
        return (req_b && !req_a) ? CH_B : CH_A;
    endfunction

endpackage

// File: rtl/ds_dwell_cnt.sv
// Saturating dwell counter for the current mux holder, with an expiry flag
// against the programmable minimum dwell (a zero minimum never expires).
module ds_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_en,
    input  logic [DWELL_W-1:0] i_min_dwell,
    output logic               o_expired
);

    logic [DWELL_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= DWELL_W'(1);
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + DWELL_W'(1);
        end
    end

    assign o_expired = (i_min_dwell != '0) && (r_count >= i_min_dwell);

endmodule

// File: rtl/ds_mux_sched.sv
// Round-robin scheduler for the shared 1-bit 2:1 bitstream mux: drives the mux
// select, grants, and a guard-interval hold on every switchover.
module ds_mux_sched
    import ds_mux_pkg::*;
#(
    parameter int GUARD   = 2,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [DWELL_W-1:0] min_dwell,
    output logic               grant_a,
    output logic               grant_b,
    output logic               sel,
    output logic               hold,
    output logic               busy
);

    localparam int                 GUARD_W    = $clog2(GUARD + 1);
    localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD);

    state_e             r_state;
    chan_e              r_last;
    chan_e              r_target;
    logic [GUARD_W-1:0] r_guard;
    logic               r_grant_a;
    logic               r_grant_b;
    logic               r_sel;
    logic               r_hold;
    logic               r_busy;

    chan_e w_target;
    chan_e w_next_chan;
    logic  w_to_grant;
    logic  w_to_switch;
    logic  w_to_idle;
    logic  w_expired;
    logic  w_guard_done;
    logic  w_dwell_en;

    assign w_target     = arb_target(req_a, req_b, r_last);
    assign w_guard_done = (r_guard == GUARD_W'(1));
    assign w_dwell_en   = (r_state == GNT_A) || (r_state == GNT_B);

    ds_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_to_grant),
        .i_en        (w_dwell_en),
        .i_min_dwell (min_dwell),
        .o_expired   (w_expired)
    );

    // Transition decode; the register block below applies exactly one of these.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no latch is inferred.
        w_to_grant  = 1'b0;
        w_to_switch = 1'b0;
        w_to_idle   = 1'b0;
        w_next_chan = w_target;
        case (r_state)
            IDLE: begin
                if (req_a || req_b) begin
                    if (chan_sel(w_target) == r_sel) begin
                        w_to_grant = 1'b1;
                    end else begin
                        w_to_switch = 1'b1;
                    end
                end
            end
            GNT_A: begin
                w_next_chan = CH_B;
                if (!req_a) begin
                    w_to_switch = req_b;
                    w_to_idle   = !req_b;
                end else if (req_b && w_expired) begin
                    w_to_switch = 1'b1;
                end
            end
            GNT_B: begin
                w_next_chan = CH_A;
                if (!req_b) begin
                    w_to_switch = req_a;
                    w_to_idle   = !req_a;
                end else if (req_a && w_expired) begin
                    w_to_switch = 1'b1;
                end
            end
            SWITCH: begin
                // Target is frozen at entry; request changes only matter at guard exit.
                w_next_chan = r_target;
                if (w_guard_done) begin
                    if ((r_target == CH_A) ? req_a : req_b) begin
                        w_to_grant = 1'b1;
                    end else begin
                        w_to_idle = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last    <= CH_B;
            r_target  <= CH_A;
            r_guard   <= '0;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_sel     <= SEL_A;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (w_to_grant) begin
            r_state   <= (w_next_chan == CH_A) ? GNT_A : GNT_B;
            r_last    <= w_next_chan;
            r_guard   <= '0;
            r_grant_a <= (w_next_chan == CH_A);
            r_grant_b <= (w_next_chan == CH_B);
            r_hold    <= 1'b0;
            r_busy    <= 1'b1;
        end else if (w_to_switch) begin
            r_state   <= SWITCH;
            r_target  <= w_next_chan;
            r_guard   <= GUARD_LOAD;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_sel     <= chan_sel(w_next_chan);
            r_hold    <= 1'b1;
            r_busy    <= 1'b1;
        end else if (w_to_idle) begin
            // sel is left where it is so a returning request for the same side is granted directly.
            r_state   <= IDLE;
            r_guard   <= '0;
            r_grant_a <= 1'b0;
            r_grant_b <= 1'b0;
            r_hold    <= 1'b0;
            r_busy    <= 1'b0;
        end else if (r_state == SWITCH) begin
            r_guard <= r_guard - GUARD_W'(1);
        end
    end

    assign grant_a = r_grant_a;
    assign grant_b = r_grant_b;
    assign sel     = r_sel;
    assign hold    = r_hold;
    assign busy    = r_busy;

endmodule
